// File: rtl/change_display_driver.sv
// change_display_driver: captures a binary cent amount, converts it to BCD with a
// sequential double-dabble engine and time-multiplexes it as DD.CC on a 4-digit
// common-anode seven-segment display, with optional whole-display blinking.
module change_display_driver #(
   parameter int VAL_W       = 14,
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [VAL_W-1:0] value,
   input  logic             load,
   input  logic             blink_en,
   output logic             busy,
   output logic [7:0]       seg,
   output logic [3:0]       an
);

   localparam int CNT_W = $clog2(VAL_W + 1);
   localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BC_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   typedef enum logic {
      S_IDLE,
      S_CONV
   } state_t;

   state_t           state_q, state_d;
   logic [VAL_W-1:0] bin_q;
   logic [15:0]      bcd_q;
   logic [15:0]      bcd_adj;
   logic [15:0]      bcd_next;
   logic [15:0]      digits_q;
   logic [CNT_W-1:0] shift_cnt;
   logic [VAL_W-1:0] value_sat;
   logic             start;
   logic             last_shift;

   logic [RC_W-1:0]  refresh_cnt;
   logic             refresh_tc;
   logic [1:0]       digit_idx;
   logic [BC_W-1:0]  blink_cnt;
   logic             blink_on;
   logic             blank;
   logic [7:0]       slot_seg;
   logic [3:0]       slot_an;

   // Active-low segment pattern {dp,g,f,e,d,c,b,a} for one BCD digit, dp off.
   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   // Add-3 correction on every nibble that is 5 or more, ahead of the shift.
   function automatic logic [15:0] add3(input logic [15:0] b);
      logic [15:0] r;
      r = b;
      for (int unsigned i = 0; i < 4; i++) begin
         if (b[i*4 +: 4] >= 4'd5)
            r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   // Clamp the input to the largest displayable amount and derive datapath controls.
   always_comb begin
      value_sat  = (32'(value) > 32'd9999) ? VAL_W'(9999) : value;
      start      = load && (state_q == S_IDLE);
      last_shift = (state_q == S_CONV) && (shift_cnt == CNT_W'(VAL_W - 1));
      bcd_adj    = add3(bcd_q);
      bcd_next   = {bcd_adj[14:0], bin_q[VAL_W-1]};
      busy       = (state_q == S_CONV);
   end

   // Conversion FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Conversion FSM next state: idle until a load, then exactly VAL_W shift cycles.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (load) state_d = S_CONV;
         S_CONV:  if (last_shift) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Double-dabble shift register; displayed digits only update on the final shift.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bin_q     <= '0;
         bcd_q     <= '0;
         shift_cnt <= '0;
         digits_q  <= '0;
      end else if (start) begin
         bin_q     <= value_sat;
         bcd_q     <= '0;
         shift_cnt <= '0;
      end else if (state_q == S_CONV) begin
         bin_q     <= {bin_q[VAL_W-2:0], 1'b0};
         bcd_q     <= bcd_next;
         shift_cnt <= shift_cnt + 1'b1;
         if (last_shift)
            digits_q <= bcd_next;
      end
   end

   // Digit slot refresh counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            refresh_cnt <= '0;
      else if (refresh_tc) refresh_cnt <= '0;
      else                 refresh_cnt <= refresh_cnt + 1'b1;
   end

   assign refresh_tc = (refresh_cnt == RC_W'(REFRESH_DIV - 1));

   // Blink phase generator; held in the on phase with a cleared counter when disabled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (!blink_en) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (blink_cnt == BC_W'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         blink_on  <= ~blink_on;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   assign blank = blink_en && !blink_on;

   // Segment and anode pattern for the current digit slot (DD.CC layout).
   always_comb begin
      slot_seg = 8'hFF;
      slot_an  = 4'hF;
      case (digit_idx)
         2'd0: begin
            slot_an  = 4'b1110;
            slot_seg = seg7(digits_q[3:0]);
         end
         2'd1: begin
            slot_an  = 4'b1101;
            slot_seg = seg7(digits_q[7:4]);
         end
         2'd2: begin
            slot_an  = 4'b1011;
            slot_seg = seg7(digits_q[11:8]) & 8'h7F;
         end
         default: begin
            slot_an  = 4'b0111;
            slot_seg = (digits_q[15:12] == 4'd0) ? 8'hFF : seg7(digits_q[15:12]);
         end
      endcase
   end

   // Registered seg/an change together at each slot boundary, then the index advances.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg       <= 8'hFF;
         an        <= 4'hF;
         digit_idx <= '0;
      end else if (refresh_tc) begin
         seg       <= slot_seg;
         an        <= blank ? 4'hF : slot_an;
         digit_idx <= digit_idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_change_display_driver.sv
// Self-checking bench for change_display_driver using small dividers.
module tb_change_display_driver;

   localparam int VAL_W       = 14;
   localparam int REFRESH_DIV = 4;
   localparam int BLINK_DIV   = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [VAL_W-1:0] value = '0;
   logic             load = 1'b0;
   logic             blink_en = 1'b0;
   logic             busy;
   logic [7:0]       seg;
   logic [3:0]       an;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [VAL_W-1:0] v;
      logic [31:0]      frame;   // {an3 seg, an2 seg, an1 seg, an0 seg}
   } vec_t;

   vec_t vecs[8];

   change_display_driver #(
      .VAL_W(VAL_W),
      .REFRESH_DIV(REFRESH_DIV),
      .BLINK_DIV(BLINK_DIV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .value(value),
      .load(load),
      .blink_en(blink_en),
      .busy(busy),
      .seg(seg),
      .an(an)
   );

   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [VAL_W-1:0] v);
      @(negedge clk);
      value = v;
      load  = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   task automatic check_busy_len(input string name);
      int cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) cnt++;
         else break;
      end
      check(name, cnt, 14);
   endtask

   task automatic check_frame(input string name, input logic [31:0] exp);
      logic [7:0] got[4];
      for (int k = 0; k < 4; k++) got[k] = 'x;
      repeat (REFRESH_DIV + 1) @(negedge clk);
      for (int i = 0; i < 4 * REFRESH_DIV; i++) begin
         @(negedge clk);
         case (an)
            4'b1110: got[0] = seg;
            4'b1101: got[1] = seg;
            4'b1011: got[2] = seg;
            4'b0111: got[3] = seg;
            default: ;
         endcase
      end
      for (int k = 0; k < 4; k++)
         check($sformatf("%s an[%0d] seg", name, k), {24'h0, got[k]}, {24'h0, exp[8*k +: 8]});
   endtask

   initial begin
      int cnt;
      int ntrans;
      int trans[16];
      bit samp[160];
      logic [7:0] segs[160];
      bit found;
      int nblank;

      vecs[0] = '{v: 14'd50,    frame: 32'hFF40_92C0};
      vecs[1] = '{v: 14'd135,   frame: 32'hFF79_B092};
      vecs[2] = '{v: 14'd12345, frame: 32'h9010_9090};
      vecs[3] = '{v: 14'd9999,  frame: 32'h9010_9090};
      vecs[4] = '{v: 14'd10000, frame: 32'h9010_9090};
      vecs[5] = '{v: 14'd0,     frame: 32'hFF40_C0C0};
      vecs[6] = '{v: 14'd1000,  frame: 32'hF940_C0C0};
      vecs[7] = '{v: 14'd999,   frame: 32'hFF10_9090};

      // Reset state
      repeat (3) @(negedge clk);
      check("reset seg", {24'h0, seg}, 32'hFF);
      check("reset an", {28'h0, an}, 32'hF);
      check("reset busy", {31'h0, busy}, 32'h0);

      // Release: outputs stay blank until the first terminal count
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("pre-tc an", {28'h0, an}, 32'hF);
      check("pre-tc seg", {24'h0, seg}, 32'hFF);
      @(negedge clk);
      check("first slot an", {28'h0, an}, 32'hE);
      check("first slot seg", {24'h0, seg}, 32'hC0);
      check_frame("reset frame", 32'hFF40_C0C0);

      // Table-driven conversions
      for (int i = 0; i < 8; i++) begin
         do_load(vecs[i].v);
         check_busy_len($sformatf("busy len v=%0d", vecs[i].v));
         check_frame($sformatf("frame v=%0d", vecs[i].v), vecs[i].frame);
      end

      // Load during conversion is ignored and does not stretch busy
      do_load(14'd100);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 3) begin
            value = 14'd15;
            load  = 1'b1;
         end
         if (i == 4) load = 1'b0;
         if (busy) cnt++;
         else break;
      end
      load = 1'b0;
      check("busy len with ignored load", cnt, 14);
      check_frame("frame after ignored load", 32'hFF79_C0C0);

      // Reset in the middle of a conversion
      do_load(14'd9999);
      repeat (5) @(negedge clk);
      check("busy mid conversion", {31'h0, busy}, 32'h1);
      #2 rst = 1'b0;
      #1;
      check("async reset busy", {31'h0, busy}, 32'h0);
      check("async reset seg", {24'h0, seg}, 32'hFF);
      check("async reset an", {28'h0, an}, 32'hF);
      @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy) cnt++;
      end
      check("busy after aborted conversion", cnt, 0);
      check_frame("frame after mid reset", 32'hFF40_C0C0);

      // Blink: anodes blank for BLINK_DIV cycles, then normal for BLINK_DIV cycles
      @(negedge clk);
      blink_en = 1'b1;
      for (int i = 0; i < 160; i++) begin
         @(negedge clk);
         samp[i] = (an == 4'hF);
         segs[i] = seg;
      end
      ntrans = 0;
      for (int i = 1; i < 160; i++) begin
         if (samp[i] != samp[i-1] && ntrans < 16) begin
            trans[ntrans] = i;
            ntrans++;
         end
      end
      check("blink transitions >= 3", {31'h0, ntrans >= 3}, 32'h1);
      for (int k = 0; k + 1 < ntrans; k++) begin
         check($sformatf("blink run %0d length", k), trans[k+1] - trans[k], BLINK_DIV);
         if (samp[trans[k]]) begin
            cnt = 0;
            for (int j = trans[k] + 1; j < trans[k+1]; j++)
               if (segs[j] != segs[j-1]) cnt++;
            check($sformatf("seg runs while blanked %0d", k), {31'h0, cnt > 0}, 32'h1);
         end
      end

      // Drop blink_en during the off phase: anodes return within one slot
      found = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (an == 4'hF) begin
            found = 1'b1;
            break;
         end
      end
      check("blink off phase reached", {31'h0, found}, 32'h1);
      blink_en = 1'b0;
      found = 1'b0;
      for (int i = 0; i < REFRESH_DIV + 2; i++) begin
         @(negedge clk);
         if (an != 4'hF) begin
            found = 1'b1;
            break;
         end
      end
      check("anodes back after blink_en drop", {31'h0, found}, 32'h1);
      nblank = 0;
      repeat (64) begin
         @(negedge clk);
         if (an == 4'hF) nblank++;
      end
      check("no blanking with blink_en low", nblank, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
